regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register-file write arbiter with 2-deep request FIFOs
// Optional REGFILE_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed MEM priority.

module regfile_arb_fifo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [4:0]  push_rd,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [4:0]  head_rd,
  output logic [31:0] head_data,
  output logic [31:0] occ
);

  logic [1:0]  vld;
  logic [4:0]  rd_q   [2];
  logic [31:0] data_q [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        push_en;
  logic        pop_en;

  assign full      = &vld;
  assign empty     = ~|vld;
  assign push_en   = push & ~full;
  assign pop_en    = pop & ~empty;
  assign head_rd   = rd_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Push and pop never target the same slot: that needs count 0 (no pop) or 2 (no push).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rd_q[0]   <= '0;
      rd_q[1]   <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      if (pop_en) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= ~rd_ptr;
      end
      if (push_en) begin
        vld[wr_ptr]    <= 1'b1;
        rd_q[wr_ptr]   <= push_rd;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= ~wr_ptr;
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < 2; i++) begin
      if (vld[i]) occ = occ | (32'd1 << rd_q[i]);
    end
  end

endmodule

module regfile_write_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        we,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic [31:0] pending
);

  logic        alu_full, alu_empty, mem_full, mem_empty;
  logic [4:0]  alu_head_rd, mem_head_rd, grant_rd;
  logic [31:0] alu_head_data, mem_head_data, grant_data;
  logic [31:0] alu_occ, mem_occ;
  logic        grant_alu, grant_mem, tie_to_mem;

  assign alu_ready = ~alu_full;
  assign mem_ready = ~mem_full;

  regfile_arb_fifo u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_valid),
    .push_rd   (alu_rd),
    .push_data (alu_data),
    .pop       (grant_alu),
    .full      (alu_full),
    .empty     (alu_empty),
    .head_rd   (alu_head_rd),
    .head_data (alu_head_data),
    .occ       (alu_occ)
  );

  regfile_arb_fifo u_mem_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (mem_valid),
    .push_rd   (mem_rd),
    .push_data (mem_data),
    .pop       (grant_mem),
    .full      (mem_full),
    .empty     (mem_empty),
    .head_rd   (mem_head_rd),
    .head_data (mem_head_data),
    .occ       (mem_occ)
  );

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  logic last_grant_mem;

  assign tie_to_mem = ~last_grant_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_mem <= 1'b0;
    end else if (grant_alu | grant_mem) begin
      last_grant_mem <= grant_mem;
    end
  end
`else
  assign tie_to_mem = 1'b1;
`endif

  assign grant_mem  = ~mem_empty & (alu_empty | tie_to_mem);
  assign grant_alu  = ~alu_empty & ~grant_mem;
  assign grant_rd   = grant_mem ? mem_head_rd   : alu_head_rd;
  assign grant_data = grant_mem ? mem_head_data : alu_head_data;

  // x0 entries are consumed here but never reach the write port, so a3/wd3 keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we  <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else if ((grant_alu | grant_mem) && (grant_rd != 5'd0)) begin
      we  <= 1'b1;
      a3  <= grant_rd;
      wd3 <= grant_data;
    end else begin
      we  <= 1'b0;
    end
  end

  assign pending = (alu_occ | mem_occ | (we ? (32'd1 << a3) : 32'd0)) & ~32'd1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter (both arbitration builds)

module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0]  alu_rd = '0, mem_rd = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, we;
  logic [4:0]  a3;
  logic [31:0] wd3, pending;

  int errors = 0;
  int checks = 0;
  int alu_n = 0;
  int mem_n = 0;
  logic [36:0] alu_q[$];
  logic [36:0] mem_q[$];

  regfile_write_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .we        (we),
    .a3        (a3),
    .wd3       (wd3),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_alu();
    alu_rd   = 5'(8 + (alu_n % 8));
    alu_data = 32'hA000_0000 + 32'(alu_n);
    alu_n++;
  endtask

  task automatic next_mem();
    mem_rd   = 5'(20 + (mem_n % 8));
    mem_data = 32'hB000_0000 + 32'(mem_n);
    mem_n++;
  endtask

  // Acceptance capture and write-port scoreboard; inputs change only just after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_valid && alu_ready && alu_rd != 5'd0) alu_q.push_back({alu_rd, alu_data});
      if (mem_valid && mem_ready && mem_rd != 5'd0) mem_q.push_back({mem_rd, mem_data});
      if (we) begin
        checks++;
        if (alu_q.size() > 0 && alu_q[0] == {a3, wd3}) void'(alu_q.pop_front());
        else if (mem_q.size() > 0 && mem_q[0] == {a3, wd3}) void'(mem_q.pop_front());
        else begin
          errors++;
          $display("FAIL sb_write: got a3=%0d wd3=%h, required head of alu_q or mem_q", a3, wd3);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drain_and_check(input string name);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    repeat (12) tick();
    chk({name, "_alu_q_empty"}, 32'(alu_q.size()), 32'd0);
    chk({name, "_mem_q_empty"}, 32'(mem_q.size()), 32'd0);
  endtask

  initial begin
    logic [4:0] exp_a3 [4];
    logic       a_acc, m_acc, saw_alu, mem_checked;
    int         acnt, mcnt;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_a3", 32'(a3), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);

    // Single uncontested ALU write
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("single_pend_k", pending, 32'h0000_0020);
    chk("single_we_k", 32'(we), 32'd0);
    tick();
    @(negedge clk);
    chk("single_we", 32'(we), 32'd1);
    chk("single_a3", 32'(a3), 32'd5);
    chk("single_wd3", wd3, 32'hDEADBEEF);
    chk("single_pend_w", pending, 32'h0000_0020);
    tick();
    @(negedge clk);
    chk("single_we_off", 32'(we), 32'd0);
    chk("single_pend_off", pending, 32'd0);
    chk("single_a3_hold", 32'(a3), 32'd5);

    // Two back-to-back ties
    exp_a3[0] = 5'd4;
    exp_a3[1] = RR ? 5'd3 : 5'd7;
    exp_a3[2] = RR ? 5'd7 : 5'd3;
    exp_a3[3] = 5'd6;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h2;
    tick();
    alu_rd = 5'd6; alu_data = 32'h3;
    mem_rd = 5'd7; mem_data = 32'h4;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk("tie_pending", pending, 32'h0000_00D8);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick();
        @(negedge clk);
      end
      chk($sformatf("tie_we_%0d", i), 32'(we), 32'd1);
      chk($sformatf("tie_a3_%0d", i), 32'(a3), 32'(exp_a3[i]));
    end
    tick();
    @(negedge clk);
    chk("tie_we_off", 32'(we), 32'd0);

    // x0 write is consumed but dropped
    tick();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("x0_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("x0_pend_k", pending, 32'd0);
    chk("x0_ready_k", 32'(alu_ready), 32'd1);
    tick();
    @(negedge clk);
    chk("x0_we", 32'(we), 32'd0);
    chk("x0_pend", pending, 32'd0);
    chk("x0_a3_hold", 32'(a3), 32'd6);
    chk("x0_wd3_hold", wd3, 32'h3);

    // MEM sends three while ALU floods
    acnt = 0; mcnt = 0; mem_checked = 1'b0;
    tick();
    next_alu(); alu_valid = 1'b1;
    next_mem(); mem_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!mem_checked && mcnt == 3) begin
        chk("flood_mem_ready", 32'(mem_ready), RR ? 32'd0 : 32'd1);
        mem_checked = 1'b1;
      end
      a_acc = alu_valid && alu_ready;
      m_acc = mem_valid && mem_ready;
      tick();
      if (a_acc) begin acnt++; next_alu(); end
      if (m_acc) begin
        mcnt++;
        if (mcnt == 3) mem_valid = 1'b0;
        else next_mem();
      end
    end
    chk("flood_mem_cnt", 32'(mcnt), 32'd3);
    drain_and_check("flood");

    // Reset with both FIFOs occupied and a write in flight
    tick();
    next_alu(); alu_valid = 1'b1;
    next_mem(); mem_valid = 1'b1;
    tick();
    next_alu(); next_mem();
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("prerst_alu_full", 32'(alu_ready), 32'd0);
    chk("prerst_we", 32'(we), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_pending", pending, 32'd0);
    chk("midrst_we", 32'(we), 32'd0);
    chk("midrst_a3", 32'(a3), 32'd0);
    alu_q.delete();
    mem_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_alu_ready", 32'(alu_ready), 32'd1);
    chk("postrst_mem_ready", 32'(mem_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("postrst_we_%0d", c), 32'(we), 32'd0);
      chk($sformatf("postrst_pend_%0d", c), pending, 32'd0);
    end

    // MEM streams continuously while ALU also requests
    acnt = 0; mcnt = 0; saw_alu = 1'b0;
    tick();
    next_alu(); alu_valid = 1'b1;
    next_mem(); mem_valid = 1'b1;
    for (int c = 0; c < 30 && mcnt < 6; c++) begin
      @(negedge clk);
`ifndef REGFILE_ARB_ROUND_ROBIN_EN
      if (c >= 2) chk($sformatf("starve_alu_ready_%0d", c), 32'(alu_ready), 32'd0);
`endif
      if (we && a3 < 5'd20) saw_alu = 1'b1;
      a_acc = alu_valid && alu_ready;
      m_acc = mem_valid && mem_ready;
      tick();
      if (a_acc) begin acnt++; next_alu(); end
      if (m_acc) begin mcnt++; next_mem(); end
      if (mcnt == 6) begin
        mem_valid = 1'b0;
        alu_valid = 1'b0;
      end
    end
    chk("starve_mem_cnt", 32'(mcnt), 32'd6);
    chk("starve_saw_alu", 32'(saw_alu), RR ? 32'd1 : 32'd0);
    drain_and_check("starve");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
